// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sweep checker: FSM states,
// counter width and the maximal-length LFSR tap masks for widths 3..8.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int CNT_W = 16;

  // Bit k-1 set for each x^k term (constant term implied); all maximal length.
  localparam logic [7:0] LFSR_TAPS [3:8] = '{
    8'h06,  // x^3+x^2+1
    8'h0C,  // x^4+x^3+1
    8'h14,  // x^5+x^3+1
    8'h30,  // x^6+x^5+1
    8'h60,  // x^7+x^6+1
    8'hB8   // x^8+x^6+x^5+x^4+1
  };

endpackage

// File: rtl/lfsr_gen.sv
// N-bit Fibonacci LFSR: shifts left, feedback is the XOR of the tapped bits.
// load takes priority over step.
module lfsr_gen
  import bist_pkg::*;
#(
  parameter int              N    = 3,
  parameter logic [N-1:0]    TAPS = (N)'(LFSR_TAPS[N])
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         step,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      q_d = {q_q[N-2:0], ^(q_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bist_sweep_checker.sv
// Stimulus generator / response checker for a "vector < THRESH" circuit:
// drives dut_in, waits SETTLE cycles, samples dut_out and tallies mismatches.
//
// state | meaning
// IDLE  | waiting for start; outputs hold results of the last run
// WAIT  | dut_in held stable for SETTLE cycles
// CHECK | dut_out sampled and compared; advance or finish
// DONE  | one-cycle done pulse, pass updated
module bist_sweep_checker
  import bist_pkg::*;
#(
  parameter int N         = 3,
  parameter int THRESH    = 3,
  parameter int SETTLE    = 1,
  parameter int RAND_VECS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [N-1:0]     seed,
  output logic [N-1:0]     dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [N-1:0]     first_err_vec,
  output logic             first_err_valid
);

  // Threshold held at N+1 bits so THRESH = 2^N yields an always-1 expectation.
  localparam logic [N:0]       THRESH_W  = (N+1)'(THRESH);
  localparam logic [N-1:0]     TAPS      = (N)'(LFSR_TAPS[N]);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(RAND_VECS - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     dut_in_q, dut_in_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [N-1:0]     fev_q, fev_d;
  logic             fv_q, fv_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N-1:0]     seed_eff;
  logic [N-1:0]     lfsr_q;
  logic             lfsr_load;
  logic             lfsr_step;
  logic             exp_out;
  logic             last_vec;

  assign seed_eff = (seed == '0) ? (N)'(1) : seed;
  assign exp_out  = ({1'b0, dut_in_q} < THRESH_W);
  assign last_vec = mode_q ? (idx_q == LAST_IDX) : (dut_in_q == '1);

  // The LFSR steps on entry to CHECK so it already holds the next vector
  // when CHECK hands it to dut_in.
  lfsr_gen #(
    .N    (N),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed_eff),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  always_comb begin
    state_d   = state_q;
    dut_in_d  = dut_in_q;
    mode_d    = mode_q;
    settle_d  = settle_q;
    idx_d     = idx_q;
    err_d     = err_q;
    fev_d     = fev_q;
    fv_d      = fv_q;
    pass_d    = pass_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT;
          mode_d    = mode;
          dut_in_d  = mode ? seed_eff : '0;
          lfsr_load = 1'b1;
          settle_d  = SETTLE_LD;
          idx_d     = '0;
          err_d     = '0;
          fev_d     = '0;
          fv_d      = 1'b0;
          pass_d    = 1'b0;
        end
      end
      WAIT: begin
        if (settle_q == '0) begin
          state_d   = CHECK;
          lfsr_step = 1'b1;
        end else begin
          settle_d = settle_q - CNT_W'(1);
        end
      end
      CHECK: begin
        if (dut_out != exp_out) begin
          if (err_q != '1) begin
            err_d = err_q + CNT_W'(1);
          end
          if (!fv_q) begin
            fev_d = dut_in_q;
            fv_d  = 1'b1;
          end
        end
        if (last_vec) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = WAIT;
          settle_d = SETTLE_LD;
          idx_d    = idx_q + CNT_W'(1);
          dut_in_d = mode_q ? lfsr_q : dut_in_q + (N)'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dut_in_q <= '0;
      mode_q   <= 1'b0;
      settle_q <= '0;
      idx_q    <= '0;
      err_q    <= '0;
      fev_q    <= '0;
      fv_q     <= 1'b0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      mode_q   <= mode_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      fev_q    <= fev_d;
      fv_q     <= fv_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dut_in          = dut_in_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fv_q;

endmodule

// File: tb/tb_bist_sweep_checker.sv
// Bench for bist_sweep_checker: two instances (SETTLE=1 and SETTLE=3) share
// stimulus; a time-indexed reference model predicts every output each cycle.
module tb_bist_sweep_checker;

  localparam int N      = 3;
  localparam int THRESH = 3;
  localparam int RV     = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, mode;
  logic [2:0]  seed;
  logic [7:0]  tt;

  logic [2:0]  din0, din1, fev0, fev1;
  logic        dout0, dout1, busy0, busy1, done0, done1;
  logic        pass0, pass1, fv0, fv1;
  logic [15:0] err0, err1;

  // Circuit under test modelled as a truth table over the input vector.
  assign dout0 = tt[din0];
  assign dout1 = tt[din1];

  bist_sweep_checker #(.N(3), .THRESH(3), .SETTLE(1), .RAND_VECS(10)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .dut_in(din0), .dut_out(dout0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_vec(fev0), .first_err_valid(fv0));

  bist_sweep_checker #(.N(3), .THRESH(3), .SETTLE(3), .RAND_VECS(10)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
    .dut_in(din1), .dut_out(dout1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_vec(fev1), .first_err_valid(fv1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  bit          m_act [2];
  int          m_t   [2];
  int          m_V   [2];
  logic [2:0]  m_vec [2][16];
  bit          m_mis [2][16];
  int          acc_cyc  [2];
  int          done_lat [2];

  logic [2:0]  e_din [2];
  logic [2:0]  e_fev [2];
  logic [15:0] e_err [2];
  bit          e_busy[2], e_done[2], e_pass[2], e_fv[2];

  function automatic int sv(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // x^3+x^2+1: new low bit is bit2 xor bit1 of the old value.
  function automatic logic [2:0] lfsr_nx(input logic [2:0] v);
    int x, fb;
    x  = int'(v);
    fb = ((x >> 2) ^ (x >> 1)) & 1;
    return 3'(((x << 1) | fb) & 7);
  endfunction

  task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at cycle %0d", nm, i, act, exp, cyc);
    end
  endtask

  // Outputs as a function of t = cycles since the accepting edge.
  task automatic upd(input int i);
    int p, k, n, tend;
    p    = sv(i) + 1;
    tend = m_V[i] * p + 1;
    k    = (m_t[i] - 1) / p;
    if (k > m_V[i] - 1) k = m_V[i] - 1;
    e_din[i]  = m_vec[i][k];
    e_busy[i] = 1'b1;
    e_done[i] = (m_t[i] == tend);
    n = 0;
    e_fv[i]  = 1'b0;
    e_fev[i] = '0;
    for (int j = 0; j < m_V[i]; j++) begin
      if ((j + 1) * p < m_t[i] && m_mis[i][j]) begin
        n++;
        if (!e_fv[i]) begin
          e_fv[i]  = 1'b1;
          e_fev[i] = m_vec[i][j];
        end
      end
    end
    e_err[i]  = 16'(n);
    e_pass[i] = (m_t[i] == tend) && (n == 0);
  endtask

  always @(posedge clk) begin
    logic [2:0] v;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
        e_din[i] = '0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_pass[i] = 1'b0;
        e_err[i] = '0; e_fev[i] = '0; e_fv[i] = 1'b0;
      end else if (m_act[i]) begin
        m_t[i]++;
        if (m_t[i] > m_V[i] * (sv(i) + 1) + 1) begin
          m_act[i]  = 1'b0;
          e_busy[i] = 1'b0;
          e_done[i] = 1'b0;
        end else begin
          upd(i);
        end
      end else if (start) begin
        m_act[i]   = 1'b1;
        m_t[i]     = 1;
        acc_cyc[i] = cyc;
        if (mode) begin
          m_V[i] = RV;
          v = (seed == 3'd0) ? 3'd1 : seed;
          for (int j = 0; j < RV; j++) begin
            m_vec[i][j] = v;
            v = lfsr_nx(v);
          end
        end else begin
          m_V[i] = 1 << N;
          for (int j = 0; j < (1 << N); j++) m_vec[i][j] = 3'(j);
        end
        for (int j = 0; j < m_V[i]; j++)
          m_mis[i][j] = (tt[m_vec[i][j]] != (int'(m_vec[i][j]) < THRESH));
        upd(i);
      end
    end
  end

  task automatic check_inst(input int i, input logic [2:0] di, input logic b, input logic dn,
                            input logic p, input logic [15:0] er, input logic [2:0] fe,
                            input logic fvv);
    chk("dut_in", i, 16'(di), 16'(e_din[i]));
    chk("busy", i, 16'(b), 16'(e_busy[i]));
    chk("done", i, 16'(dn), 16'(e_done[i]));
    chk("pass", i, 16'(p), 16'(e_pass[i]));
    chk("err_count", i, er, e_err[i]);
    chk("first_err_vec", i, 16'(fe), 16'(e_fev[i]));
    chk("first_err_valid", i, 16'(fvv), 16'(e_fv[i]));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_inst(0, din0, busy0, done0, pass0, err0, fev0, fv0);
      check_inst(1, din1, busy1, done1, pass1, err1, fev1, fv1);
      if (done0) done_lat[0] = cyc - acc_cyc[0];
      if (done1) done_lat[1] = cyc - acc_cyc[1];
    end
  end

  task automatic pulse_start(input logic m, input logic [2:0] s);
    @(negedge clk);
    mode  = m;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || busy1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 0, 16'(n >= 400), 16'd0);
    @(negedge clk);
  endtask

  task automatic wait_din0(input logic [2:0] v);
    int n;
    n = 0;
    while (din0 != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("din_timeout", 0, 16'(n >= 100), 16'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; tt = 8'h07;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    rst    = 1'b0;
    chk("rst_dut_in", 0, 16'(din0), 16'd0);
    chk("rst_busy", 0, 16'(busy0), 16'd0);
    chk("rst_err", 1, err1, 16'd0);

    // Correct circuit, exhaustive sweep.
    tt = 8'h07;
    pulse_start(1'b0, 3'd0);
    wait_idle();
    chk("sweep_ok_pass", 0, 16'(pass0), 16'd1);
    chk("sweep_ok_err", 0, err0, 16'd0);
    chk("sweep_ok_fv", 0, 16'(fv0), 16'd0);
    chk("sweep_ok_lat", 0, 16'(done_lat[0]), 16'd16);
    chk("sweep_ok_lat", 1, 16'(done_lat[1]), 16'd32);
    chk("sweep_ok_pass", 1, 16'(pass1), 16'd1);

    // Circuit also answers 1 for 3'b101.
    tt = 8'h27;
    pulse_start(1'b0, 3'd0);
    wait_idle();
    chk("faulty_err", 0, err0, 16'd1);
    chk("faulty_fev", 0, 16'(fev0), 16'd5);
    chk("faulty_fv", 0, 16'(fv0), 16'd1);
    chk("faulty_pass", 0, 16'(pass0), 16'd0);

    // Inverted circuit, random mode, seed 0 replaced by 1.
    tt = 8'hF8;
    pulse_start(1'b1, 3'd0);
    chk("rand_first_vec", 0, 16'(din0), 16'd1);
    wait_idle();
    chk("rand_err", 0, err0, 16'd10);
    chk("rand_err", 1, err1, 16'd10);
    chk("rand_fev", 0, 16'(fev0), 16'd1);
    chk("rand_lat", 0, 16'(done_lat[0]), 16'd20);
    chk("rand_lat", 1, 16'(done_lat[1]), 16'd40);
    chk("model_lfsr1", 0, 16'(m_vec[0][1]), 16'd2);
    chk("model_lfsr2", 0, 16'(m_vec[0][2]), 16'd5);
    chk("model_lfsr3", 0, 16'(m_vec[0][3]), 16'd3);

    // start while busy is ignored; start right after DONE is honoured.
    tt = 8'h27;
    pulse_start(1'b0, 3'd0);
    wait_din0(3'd4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midstart_done_timeout", 0, 16'(n >= 100), 16'd0);
    chk("midstart_err_before", 0, err0, 16'd1);
    @(negedge clk);
    chk("midstart_lat", 0, 16'(done_lat[0]), 16'd16);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", 0, 16'(busy0), 16'd1);
    chk("restart_err_clear", 0, err0, 16'd0);
    wait_idle();
    chk("restart_err", 0, err0, 16'd1);

    // Reset during CHECK of vector 5.
    tt = 8'h07;
    pulse_start(1'b0, 3'd0);
    wait_din0(3'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 0, 16'(busy0), 16'd0);
    chk("midrst_dut_in", 0, 16'(din0), 16'd0);
    chk("midrst_err", 0, err0, 16'd0);
    chk("midrst_busy", 1, 16'(busy1), 16'd0);
    pulse_start(1'b0, 3'd0);
    wait_idle();
    chk("postrst_pass", 0, 16'(pass0), 16'd1);
    chk("postrst_pass", 1, 16'(pass1), 16'd1);

    // Stuck-at-0 circuit.
    tt = 8'h00;
    pulse_start(1'b0, 3'd0);
    wait_idle();
    chk("stuck0_err", 1, err1, 16'd3);
    chk("stuck0_err", 0, err0, 16'd3);
    chk("stuck0_fev", 1, 16'(fev1), 16'd0);
    chk("stuck0_fv", 1, 16'(fv1), 16'd1);
    chk("stuck0_lat", 1, 16'(done_lat[1]), 16'd32);

    // Random circuits, modes and seeds against the model.
    for (int r = 0; r < 10; r++) begin
      tt = 8'($urandom);
      pulse_start(1'($urandom_range(0, 1)), 3'($urandom));
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
